// File: rtl/ibuf_debounce_pkg.sv
// Shared types and helpers for the buffered-input debounce controller.
// Holds the per-channel FSM state encoding and the counter width helper.
package ibuf_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } dbnc_state_e;

    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/ibuf_debounce_chan.sv
// One debounce channel: pad buffer, synchronizer chain, FSM and counter.
// o_level changes only after the synced value has differed for DEBOUNCE_CYCLES cycles.
module ibuf_debounce_chan
    import ibuf_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_enable,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                   pin_buf;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    dbnc_state_e state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic level_q, level_nxt;
    logic rise_q, rise_nxt;
    logic fall_q, fall_nxt;
    logic accept;

    ibuf_tech u_ibuf (
        .i_pad  (i_pin),
        .o_core (pin_buf)
    );

    // Chain runs regardless of i_enable so s is fresh on re-enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_buf};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_STABLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_STABLE: begin
                if (i_enable && (s != level_q)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!i_enable || (s == level_q) || (cnt_q == CNT_LAST)) begin
                    state_nxt = ST_STABLE;
                end
            end
            default: state_nxt = ST_STABLE;
        endcase
    end

    always_comb begin
        cnt_nxt   = '0;
        accept    = 1'b0;
        level_nxt = level_q;
        if (i_enable && (state_q == ST_CHECK) && (s != level_q)) begin
            if (cnt_q == CNT_LAST) begin
                accept = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
        if (accept) begin
            level_nxt = s;
        end
        rise_nxt = accept & s;
        fall_nxt = accept & ~s;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/ibuf_tech.sv
// Generic input pad buffer; replaced by the vendor cell in a tech mapping.
// Behaviourally a plain wire from pad to core.
module ibuf_tech (
    input  logic i_pad,
    output logic o_core
);

    assign o_core = i_pad;

endmodule

// File: rtl/ibuf_debounce_ctrl.sv
// Debounce controller top: CHN channels plus edge-pending/irq logic.
// Define IBUF_DEBOUNCE_IRQ_EN to enable sticky edge flags and o_irq.
module ibuf_debounce_ctrl
    import ibuf_debounce_pkg::*;
#(
    parameter int             CHN             = 4,
    parameter int             SYNC_STAGES     = 2,
    parameter int             DEBOUNCE_CYCLES = 16,
    parameter logic [CHN-1:0] RST_VAL         = '0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [CHN-1:0] i_pin,
    input  logic           i_enable,
    output logic [CHN-1:0] o_level,
    output logic [CHN-1:0] o_rise,
    output logic [CHN-1:0] o_fall,
    input  logic [CHN-1:0] i_irq_mask,
    input  logic [CHN-1:0] i_pend_clr,
    output logic [CHN-1:0] o_edge_pend,
    output logic           o_irq
);

    for (genvar g = 0; g < CHN; g++) begin : g_chan
        ibuf_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (RST_VAL[g])
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_pin    (i_pin[g]),
            .i_enable (i_enable),
            .o_level  (o_level[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g])
        );
    end

`ifdef IBUF_DEBOUNCE_IRQ_EN
    logic [CHN-1:0] pend_q;
    logic           irq_q;

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~i_pend_clr)
                    | ((o_rise | o_fall) & i_irq_mask);
            irq_q  <= |pend_q;
        end
    end

    assign o_edge_pend = pend_q;
    assign o_irq       = irq_q;
`else
    logic unused_irq_in;

    assign unused_irq_in = ^{i_irq_mask, i_pend_clr};
    assign o_edge_pend   = '0;
    assign o_irq         = 1'b0;
`endif

endmodule

// File: tb/tb_ibuf_debounce_ctrl.sv
// Directed bench for ibuf_debounce_ctrl with hand-computed timing.
// Works in both the default build and with IBUF_DEBOUNCE_IRQ_EN defined.
module tb_ibuf_debounce_ctrl;

`ifdef IBUF_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_pin = '0;
    logic       i_enable = 1'b1;
    logic [3:0] o_level;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic [3:0] i_irq_mask = '0;
    logic [3:0] i_pend_clr = '0;
    logic [3:0] o_edge_pend;
    logic       o_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cnt [4];
    int fall_cnt [4];
    int last_rise_cyc [4];
    int mark;
    int r0;
    int f0;
    int any_lvl;
    int any_pulse;
    int any_irq;

    ibuf_debounce_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pin       (i_pin),
        .i_enable    (i_enable),
        .o_level     (o_level),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .i_irq_mask  (i_irq_mask),
        .i_pend_clr  (i_pend_clr),
        .o_edge_pend (o_edge_pend),
        .o_irq       (o_irq)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (o_rise[c]) begin
                    rise_cnt[c]++;
                    last_rise_cyc[c] = cyc;
                end
                if (o_fall[c]) fall_cnt[c]++;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            last_rise_cyc[c] = -1;
        end

        // 1: reset state and quiet inputs
        tick(3);
        i_rst = 1'b0;
        chk("rst_level", 32'(o_level), 32'h0);
        chk("rst_pulse", 32'({o_rise, o_fall}), 32'h0);
        chk("rst_pend", 32'({o_edge_pend, o_irq}), 32'h0);
        any_lvl = 0; any_pulse = 0; any_irq = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (o_level != 0) any_lvl++;
            if ((o_rise | o_fall) != 0) any_pulse++;
            if (o_irq) any_irq++;
        end
        chk("quiet_level", 32'(any_lvl), 32'h0);
        chk("quiet_pulse", 32'(any_pulse), 32'h0);
        chk("quiet_irq", 32'(any_irq), 32'h0);

        // 2: ch0 step, 19-edge latency, single rise
        i_pin[0] = 1'b1;
        tick(18);
        chk("ch0_lvl_e18", 32'(o_level[0]), 32'h0);
        chk("ch0_rise_e18", 32'(o_rise[0]), 32'h0);
        tick();
        chk("ch0_lvl_e19", 32'(o_level), 32'h1);
        chk("ch0_rise_e19", 32'(o_rise), 32'h1);
        tick();
        chk("ch0_rise_e20", 32'(o_rise[0]), 32'h0);
        tick(10);
        chk("ch0_rise_cnt", 32'(rise_cnt[0]), 32'h1);
        chk("ch0_fall_cnt", 32'(fall_cnt[0]), 32'h0);

        // 3: ch1 short glitch, then bounce and hold
        r0 = rise_cnt[1];
        i_pin[1] = 1'b1;
        tick(10);
        i_pin[1] = 1'b0;
        tick(30);
        chk("ch1_glitch_lvl", 32'(o_level[1]), 32'h0);
        chk("ch1_glitch_rise", 32'(rise_cnt[1] - r0), 32'h0);
        for (int b = 0; b < 3; b++) begin
            i_pin[1] = 1'b1;
            tick(5);
            i_pin[1] = 1'b0;
            tick(5);
        end
        chk("ch1_bounce_lvl", 32'(o_level[1]), 32'h0);
        mark = cyc;
        i_pin[1] = 1'b1;
        tick(25);
        chk("ch1_rise_lat", 32'(last_rise_cyc[1] - mark), 32'd19);
        chk("ch1_rise_cnt", 32'(rise_cnt[1] - r0), 32'h1);
        chk("ch1_lvl", 32'(o_level[1]), 32'h1);
        chk("ch1_fall_cnt", 32'(fall_cnt[1]), 32'h0);

        // 4: disable mid-check on ch2, then re-enable
        r0 = rise_cnt[2];
        i_pin[2] = 1'b1;
        tick(8);
        i_enable = 1'b0;
        tick(30);
        chk("ch2_dis_lvl", 32'(o_level), 32'h3);
        chk("ch2_dis_rise", 32'(rise_cnt[2] - r0), 32'h0);
        mark = cyc;
        i_enable = 1'b1;
        tick(16);
        chk("ch2_en_e16", 32'(o_level[2]), 32'h0);
        tick(9);
        chk("ch2_rise_lat", 32'(last_rise_cyc[2] - mark), 32'd17);
        chk("ch2_rise_cnt", 32'(rise_cnt[2] - r0), 32'h1);
        chk("ch2_lvl", 32'(o_level), 32'h7);

        // 5: masked edge-pending and irq, set beats clear
        i_irq_mask = 4'b0011;
        i_pin[0] = 1'b0;
        i_pin[3] = 1'b1;
        tick(19);
        chk("sim_fall0", 32'(o_fall), 32'h1);
        chk("sim_rise3", 32'(o_rise), 32'h8);
        tick();
        chk("pend_set", 32'(o_edge_pend), IRQ_EN ? 32'h1 : 32'h0);
        chk("irq_lag", 32'(o_irq), 32'h0);
        tick();
        chk("irq_set", 32'(o_irq), IRQ_EN ? 32'h1 : 32'h0);
        i_pin[0] = 1'b1;
        tick(19);
        chk("rise0_again", 32'(o_rise[0]), 32'h1);
        i_pend_clr = 4'b0001;
        tick();
        chk("set_beats_clr", 32'(o_edge_pend), IRQ_EN ? 32'h1 : 32'h0);
        tick();
        chk("pend_clr", 32'(o_edge_pend), 32'h0);
        chk("irq_hold", 32'(o_irq), IRQ_EN ? 32'h1 : 32'h0);
        i_pend_clr = 4'b0000;
        tick();
        chk("irq_clr", 32'(o_irq), 32'h0);

        // 6a: reset during ch0 check
        i_pin[0] = 1'b0;
        tick(8);
        i_rst = 1'b1;
        i_pin = 4'b0000;
        tick(2);
        i_rst = 1'b0;
        chk("rst6a_lvl", 32'(o_level), 32'h0);
        chk("rst6a_pend", 32'({o_edge_pend, o_irq}), 32'h0);
        r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
        f0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
        tick(30);
        chk("rst6a_no_rise",
            32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - r0),
            32'h0);
        chk("rst6a_no_fall",
            32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3] - f0),
            32'h0);

        // 6b: reset after acceptance with pending set
        i_pin[0] = 1'b1;
        tick(19);
        chk("rst6b_acc", 32'(o_level), 32'h1);
        tick(2);
        chk("rst6b_pend", 32'(o_edge_pend), IRQ_EN ? 32'h1 : 32'h0);
        i_rst = 1'b1;
        i_pin = 4'b0000;
        tick(2);
        i_rst = 1'b0;
        chk("rst6b_lvl", 32'(o_level), 32'h0);
        chk("rst6b_irq", 32'({o_edge_pend, o_irq}), 32'h0);
        chk("rst6b_pulse", 32'({o_rise, o_fall}), 32'h0);
        r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
        f0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
        tick(30);
        chk("rst6b_quiet",
            32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
              + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]
              - r0 - f0),
            32'h0);
        chk("rst6b_lvl_end", 32'(o_level), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
